// File: rtl/fpu_pkg.sv
// Shared FPU encodings: FP80 layout and constants, precision/rounding control
// codes, and the state encoding of the precision-rounding sequencer.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [14:0] exp;
    logic [63:0] mant;
  } fp80_t;

  localparam logic [14:0] EXP_MAX      = 15'h7FFF;
  localparam logic [63:0] MANT_INTEGER = 64'h8000_0000_0000_0000;

  localparam logic [79:0] FP80_ZERO    = 80'h0;
  localparam logic [79:0] FP80_POS_INF = {1'b0, EXP_MAX, MANT_INTEGER};

  // Precision control (8087 PC field)
  localparam logic [1:0] PC_24   = 2'b00;
  localparam logic [1:0] PC_RSVD = 2'b01;
  localparam logic [1:0] PC_53   = 2'b10;
  localparam logic [1:0] PC_64   = 2'b11;

  // Rounding control (8087 RC field)
  localparam logic [1:0] RC_NEAREST = 2'b00;
  localparam logic [1:0] RC_DOWN    = 2'b01;
  localparam logic [1:0] RC_UP      = 2'b10;
  localparam logic [1:0] RC_CHOP    = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUND  = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Full 64-bit precision (and the reserved code) leaves the operand untouched.
  function automatic logic pc_is_full(input logic [1:0] pc);
    return (pc == PC_64) || (pc == PC_RSVD);
  endfunction

endpackage

// File: rtl/fpu_mant_rounder.sv
// Combinational mantissa rounder: truncates to the selected precision and
// applies the rounding-mode increment, reporting carry-out and the flags.
module fpu_mant_rounder
  import fpu_pkg::*;
(
  input  logic [63:0] mantissa,
  input  logic [1:0]  precision_control,
  input  logic [1:0]  rounding_mode,
  input  logic        sign,
  output logic [63:0] rounded,
  output logic        carry,
  output logic        inexact,
  output logic        round_up
);

  logic [63:0] ulp;
  logic [63:0] round_mask;
  logic [63:0] sticky_mask;
  logic [63:0] keep_mask;
  logic        round_bit;
  logic        sticky;
  logic        lsb;
  logic [64:0] sum;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ulp = 64'd1;
    case (precision_control)
      PC_24:   ulp = 64'd1 << 40;
      PC_53:   ulp = 64'd1 << 11;
      default: ulp = 64'd1;
    endcase
  end

  // With a one-bit ulp both masks collapse to zero, so full precision never rounds.
  assign round_mask  = ulp >> 1;
  assign sticky_mask = (ulp - 64'd1) & ~round_mask;
  assign keep_mask   = ~(ulp - 64'd1);

  assign round_bit = |(mantissa & round_mask);
  assign sticky    = |(mantissa & sticky_mask);
  assign lsb       = |(mantissa & ulp);
  assign inexact   = round_bit | sticky;

  always_comb begin
    round_up = 1'b0;
    case (rounding_mode)
      RC_NEAREST: round_up = round_bit & (sticky | lsb);
      RC_DOWN:    round_up = sign & inexact;
      RC_UP:      round_up = ~sign & inexact;
      RC_CHOP:    round_up = 1'b0;
    endcase
  end

  assign sum     = {1'b0, mantissa & keep_mask} + (round_up ? {1'b0, ulp} : 65'd0);
  assign carry   = sum[64];
  assign rounded = carry ? MANT_INTEGER : sum[63:0];

endmodule

// File: rtl/fpu_precision_round.sv
// FP80 precision-control rounding stage: IDLE -> ROUND -> ADJUST -> DONE,
// trimming the mantissa to 24/53 bits and fixing up exponent carry/overflow.
module fpu_precision_round
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [79:0] value_in,
  input  logic [1:0]  precision_control,
  input  logic [1:0]  rounding_mode,
  output logic [79:0] result,
  output logic        done,
  output logic        busy,
  output logic        flag_inexact,
  output logic        flag_round_up,
  output logic        flag_overflow
);

  logic [1:0]  state_q;
  fp80_t       val_q;
  logic [1:0]  pc_q;
  logic [1:0]  rc_q;

  logic [63:0] rnd_mant_q;
  logic        carry_q;
  logic        inexact_q;
  logic        round_up_q;
  logic        pass_q;

  fp80_t       fin_res_q;
  logic        fin_inexact_q;
  logic        fin_round_up_q;
  logic        fin_overflow_q;

  logic [63:0] rnd_mant;
  logic        rnd_carry;
  logic        rnd_inexact;
  logic        rnd_round_up;
  logic        pass;

  fp80_t       adj_res;
  logic [14:0] exp_inc;
  logic        adj_inexact;
  logic        adj_round_up;
  logic        adj_overflow;

  fpu_mant_rounder u_mant_rounder (
    .mantissa          (val_q.mant),
    .precision_control (pc_q),
    .rounding_mode     (rc_q),
    .sign              (val_q.sign),
    .rounded           (rnd_mant),
    .carry             (rnd_carry),
    .inexact           (rnd_inexact),
    .round_up          (rnd_round_up)
  );

  // Infinities, NaNs and true zeros are never touched by precision control.
  assign pass = pc_is_full(pc_q) || (val_q.exp == EXP_MAX) ||
                ((val_q.exp == 15'd0) && (val_q.mant == 64'd0));

  always_comb begin
    adj_res      = val_q;
    adj_inexact  = 1'b0;
    adj_round_up = 1'b0;
    adj_overflow = 1'b0;
    exp_inc      = val_q.exp + 15'd1;
    if (!pass_q) begin
      adj_res.mant = rnd_mant_q;
      adj_inexact  = inexact_q;
      adj_round_up = round_up_q;
      if (carry_q) begin
        adj_res.exp  = exp_inc;
        adj_res.mant = MANT_INTEGER;
        if (exp_inc == EXP_MAX) begin
          adj_res      = FP80_POS_INF;
          adj_res.sign = val_q.sign;
          adj_overflow = 1'b1;
          adj_inexact  = 1'b1;
        end
      end else if ((val_q.exp == 15'd0) && rnd_mant_q[63]) begin
        // A denormal that rounds up into the integer bit becomes the smallest normal.
        adj_res.exp = 15'd1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      val_q          <= FP80_ZERO;
      pc_q           <= PC_24;
      rc_q           <= RC_NEAREST;
      rnd_mant_q     <= 64'd0;
      carry_q        <= 1'b0;
      inexact_q      <= 1'b0;
      round_up_q     <= 1'b0;
      pass_q         <= 1'b0;
      fin_res_q      <= FP80_ZERO;
      fin_inexact_q  <= 1'b0;
      fin_round_up_q <= 1'b0;
      fin_overflow_q <= 1'b0;
      result         <= FP80_ZERO;
      done           <= 1'b0;
      flag_inexact   <= 1'b0;
      flag_round_up  <= 1'b0;
      flag_overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            val_q   <= value_in;
            pc_q    <= precision_control;
            rc_q    <= rounding_mode;
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          rnd_mant_q <= rnd_mant;
          carry_q    <= rnd_carry;
          inexact_q  <= rnd_inexact;
          round_up_q <= rnd_round_up;
          pass_q     <= pass;
          state_q    <= ST_ADJUST;
        end
        ST_ADJUST: begin
          fin_res_q      <= adj_res;
          fin_inexact_q  <= adj_inexact;
          fin_round_up_q <= adj_round_up;
          fin_overflow_q <= adj_overflow;
          state_q        <= ST_DONE;
        end
        ST_DONE: begin
          // Outputs change only here, so they stay stable from done until the next result.
          result        <= fin_res_q;
          flag_inexact  <= fin_inexact_q;
          flag_round_up <= fin_round_up_q;
          flag_overflow <= fin_overflow_q;
          done          <= 1'b1;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_precision_round.sv
// Self-checking bench for fpu_precision_round: directed spec vectors plus
// randomized operands scored against an independent rounding model.
module tb_fpu_precision_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [79:0] value_in;
  logic [1:0]  precision_control;
  logic [1:0]  rounding_mode;
  logic [79:0] result;
  logic        done;
  logic        busy;
  logic        flag_inexact;
  logic        flag_round_up;
  logic        flag_overflow;

  typedef struct packed {
    logic [79:0] res;
    logic        inexact;
    logic        round_up;
    logic        overflow;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fpu_precision_round dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .value_in          (value_in),
    .precision_control (precision_control),
    .rounding_mode     (rounding_mode),
    .result            (result),
    .done              (done),
    .busy              (busy),
    .flag_inexact      (flag_inexact),
    .flag_round_up     (flag_round_up),
    .flag_overflow     (flag_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference model: integer view of kept part and remainder, compared against half an ulp.
  function automatic exp_t model(input logic [79:0] v, input logic [1:0] pc, input logic [1:0] rc);
    exp_t        r;
    logic        s;
    logic [14:0] e;
    logic [63:0] m, kept, rem, half;
    logic        inc;
    int          drop;
    s = v[79];
    e = v[78:64];
    m = v[63:0];
    r = '{res: v, inexact: 1'b0, round_up: 1'b0, overflow: 1'b0};
    if (pc == 2'b11 || pc == 2'b01 || e == 15'h7FFF || (e == 15'd0 && m == 64'd0)) return r;
    drop = (pc == 2'b00) ? 40 : 11;
    kept = m >> drop;
    rem  = m & ((64'd1 << drop) - 64'd1);
    half = 64'd1 << (drop - 1);
    case (rc)
      2'b00:   inc = (rem > half) || (rem == half && kept[0]);
      2'b01:   inc = s && (rem != 64'd0);
      2'b10:   inc = !s && (rem != 64'd0);
      default: inc = 1'b0;
    endcase
    r.inexact  = (rem != 64'd0);
    r.round_up = inc;
    kept = kept + {63'd0, inc};
    if ((kept >> (64 - drop)) != 64'd0) begin
      e = e + 15'd1;
      m = 64'h8000_0000_0000_0000;
      if (e == 15'h7FFF) begin
        r.overflow = 1'b1;
        r.inexact  = 1'b1;
      end
    end else begin
      m = kept << drop;
      if (e == 15'd0 && m[63]) e = 15'd1;
    end
    r.res = {s, e, m};
    return r;
  endfunction

  // One operation; poke pulses enable with other operands while busy.
  task automatic run_op(input string tag, input logic [79:0] v, input logic [1:0] pc,
                        input logic [1:0] rc, input exp_t want, input logic poke);
    exp_t got_exp;
    int   cycles;
    int   extra;
    logic seen;
    exp_q.push_back(want);
    @(negedge clk);
    value_in = v;
    precision_control = pc;
    rounding_mode = rc;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = poke;
    value_in = ~v;
    precision_control = ~pc;
    rounding_mode = ~rc;
    check({tag, "_busy"}, busy, 1);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 8) begin
      @(posedge clk); #1;
      enable = 1'b0;
      cycles++;
      if (done) seen = 1'b1;
    end
    got_exp = exp_q.pop_front();
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, cycles, 3);
      check({tag, "_result"}, result, got_exp.res);
      check({tag, "_flags"}, {flag_inexact, flag_round_up, flag_overflow},
            {got_exp.inexact, got_exp.round_up, got_exp.overflow});
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_hold"}, result, got_exp.res);
      if (poke) begin
        extra = 0;
        repeat (6) begin
          @(posedge clk); #1;
          if (done) extra++;
        end
        check({tag, "_busy_enable_ignored"}, extra, 0);
      end
    end
  endtask

  initial begin
    logic [79:0] v;
    logic [1:0]  pc, rc;
    logic [14:0] e;
    int          dones;

    reset = 1'b1;
    enable = 1'b0;
    value_in = '0;
    precision_control = 2'b00;
    rounding_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {result, done, busy, flag_inexact, flag_round_up, flag_overflow}, 96'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("sqrt2_pc24", 80'h3FFF_B504F333F9DE6484, 2'b00, 2'b00, '{80'h3FFF_B504F30000000000, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_op("carry_pc53", 80'h3FFF_FFFFFFFFFFFFFFFF, 2'b10, 2'b00, '{80'h4000_8000000000000000, 1'b1, 1'b1, 1'b0}, 1'b1);
    run_op("tie_even",   80'h3FFF_8000008000000000, 2'b00, 2'b00, '{80'h3FFF_8000000000000000, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_op("tie_odd",    80'h3FFF_8000018000000000, 2'b00, 2'b00, '{80'h3FFF_8000020000000000, 1'b1, 1'b1, 1'b0}, 1'b0);
    run_op("ovf_rn",     80'h7FFE_FFFFFFFFFFFFFFFF, 2'b00, 2'b00, '{80'h7FFF_8000000000000000, 1'b1, 1'b1, 1'b1}, 1'b0);
    run_op("ovf_chop",   80'h7FFE_FFFFFFFFFFFFFFFF, 2'b00, 2'b11, '{80'h7FFE_FFFFFF0000000000, 1'b1, 1'b0, 1'b0}, 1'b0);
    run_op("neg_ovf_dn", 80'hFFFE_FFFFFFFFFFFFFFFF, 2'b00, 2'b01, '{80'hFFFF_8000000000000000, 1'b1, 1'b1, 1'b1}, 1'b0);
    run_op("nan_pass",   80'h7FFF_C000000000000000, 2'b00, 2'b00, '{80'h7FFF_C000000000000000, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op("pc11_pass",  80'h3FFF_B504F333F9DE6484, 2'b11, 2'b10, '{80'h3FFF_B504F333F9DE6484, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op("pc01_pass",  80'h3FFF_B504F333F9DE6484, 2'b01, 2'b00, '{80'h3FFF_B504F333F9DE6484, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op("zero_pass",  80'h0000_0000000000000000, 2'b00, 2'b10, '{80'h0000_0000000000000000, 1'b0, 1'b0, 1'b0}, 1'b0);
    run_op("denorm_up",  80'h0000_7FFFFFFFFFFFFFFF, 2'b00, 2'b00, '{80'h0001_8000000000000000, 1'b1, 1'b1, 1'b0}, 1'b0);
    run_op("neg_down",   80'hC000_8000000000000001, 2'b10, 2'b01, '{80'hC000_8000000000000800, 1'b1, 1'b1, 1'b0}, 1'b0);
    run_op("neg_up",     80'hC000_8000000000000001, 2'b10, 2'b10, '{80'hC000_8000000000000000, 1'b1, 1'b0, 1'b0}, 1'b0);

    // Reset while the operation sits in ROUND: it must vanish without done.
    @(negedge clk);
    value_in = 80'h3FFF_FFFFFFFFFFFFFFFF;
    precision_control = 2'b00;
    rounding_mode = 2'b00;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_outputs", {result, done, busy, flag_inexact, flag_round_up, flag_overflow}, 96'd0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op("post_reset", 80'h3FFF_8000018000000000, 2'b00, 2'b00, '{80'h3FFF_8000020000000000, 1'b1, 1'b1, 1'b0}, 1'b0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       e = 15'h3FFF;
        1:       e = 15'h7FFE;
        2:       e = 15'h0000;
        3:       e = 15'h7FFF;
        default: e = 15'($urandom);
      endcase
      v = {1'($urandom), e, $urandom, $urandom};
      if (e == 15'd0) v[63] = 1'b0;
      else v[63] = 1'b1;
      if ($urandom_range(0, 2) == 0) v[38:0] = '1;
      pc = 2'($urandom);
      rc = 2'($urandom);
      run_op("random", v, pc, rc, model(v, pc, rc), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
